// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in / serial-out word serializer. A word captured on
//            load is presented one bit per consumed cycle, LSB-first or
//            MSB-first, with a hold (en) and a one-cycle completion pulse.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            load  - capture din/dir and start a word (IDLE or DONE only)
//            din   - parallel word, WIDTH bits
//            dir   - bit order for the captured word: 0 LSB-first, 1 MSB-first
//            en    - consume the current bit; 0 holds the current bit
//            q     - serial data bit (0 outside SHIFT)
//            busy  - high while a word is being shifted out
//            done  - one-cycle pulse after the last bit is consumed
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             en,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;
    logic [c_cnt_w-1:0] w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a load exactly like IDLE so words can run
                // back-to-back with a single gap cycle.
                c_idle, c_done: begin
                    r_done <= 1'b0;
                    if (load) begin
                        r_data  <= din;
                        r_dir   <= dir;
                        r_cnt   <= '0;
                        r_state <= c_shift;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end
                end
                // load is deliberately ignored here: the word in flight is
                // owned by the holding register until it completes.
                c_shift: begin
                    if (en) begin
                        if (r_cnt == c_last) begin
                            r_state <= c_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // MSB-first walks the register from the top; the index stays in range
    // because the counter never passes WIDTH-1.
    assign w_idx = r_dir ? (c_last - r_cnt) : r_cnt;

    assign q    = r_busy & r_data[w_idx];
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for piso_serializer (WIDTH=4). A queue of
//            pending bits models the word in flight; directed scenarios are
//            followed by a randomized run against the same model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         dir;
    logic         en;
    logic         q;
    logic         busy;
    logic         done;

    piso_serializer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .dir  (dir),
        .en   (en),
        .q    (q),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: bits still to be emitted, in emission order, plus
    // the completion flag for the cycle following the last consumed bit.
    bit mq[$];
    bit mdone = 1'b0;

    // Per-scenario capture of q on busy cycles (first bit ends up highest).
    logic [15:0] cap;
    int          nbusy;
    int          ndone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cap   = '0;
        nbusy = 0;
        ndone = 0;
    endtask

    // Apply one cycle of inputs, advance the model on the edge, then check.
    task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                        input logic dr, input logic e);
        rst  = r;
        load = l;
        din  = d;
        dir  = dr;
        en   = e;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mdone = 1'b0;
        end else if (mq.size() > 0) begin
            mdone = 1'b0;
            if (e) begin
                void'(mq.pop_front());
                mdone = (mq.size() == 0);
            end
        end else begin
            mdone = 1'b0;
            if (l)
                for (int i = 0; i < W; i++)
                    mq.push_back(dr ? d[W-1-i] : d[i]);
        end
        #1;
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        chk("done", 32'(done), 32'(mdone));
        chk("q",    32'(q),    (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        if (busy === 1'b1) begin
            cap = {cap[14:0], q};
            nbusy++;
        end
        if (done === 1'b1) ndone++;
    endtask

    initial begin
        // Reset for two cycles; outputs must be quiet.
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("reset_q",    32'(q),    32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // 1011 LSB-first: 1,1,0,1 over four busy cycles, then one done.
        clr();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("lsb_seq",   32'(cap), 32'b1101);
        chk("lsb_busy",  nbusy, 4);
        chk("lsb_done",  ndone, 1);

        // Same word MSB-first: 1,0,1,1; din/dir changes in flight ignored.
        clr();
        step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        chk("msb_seq",  32'(cap), 32'b1011);
        chk("msb_busy", nbusy, 4);
        chk("msb_done", ndone, 1);

        // 0110 with a three-cycle hold after the second bit.
        clr();
        step(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("hold_seq",  32'(cap), 32'b0111110);
        chk("hold_busy", nbusy, 7);
        chk("hold_done", ndone, 1);

        // 1111 with a competing load of 0000 during SHIFT.
        clr();
        step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("ign_seq",  32'(cap), 32'b1111);
        chk("ign_busy", nbusy, 4);
        chk("ign_done", ndone, 1);

        // Back-to-back: 1001 then 0101 accepted in the DONE cycle.
        clr();
        step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1);
        chk("b2b_gap_done", 32'(done), 32'd1);
        step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1);
        chk("b2b_restart", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("b2b_seq",  32'(cap[7:0]), 32'b10011010);
        chk("b2b_busy", nbusy, 8);
        chk("b2b_done", ndone, 2);

        // Reset mid-word aborts with no done pulse; next load accepted.
        clr();
        step(1'b0, 1'b1, 4'b1010, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        chk("abort_q",    32'(q),    32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        chk("abort_nodone", ndone, 0);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b1);
        chk("post_rst_load", 32'(busy), 32'd1);
        chk("post_rst_q",    32'(q),    32'd1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                 W'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of bits per word (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: request to capture din and start a word.
REQ-005 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port dir, input, 1 bit: bit order, 0 = LSB-first, 1 = MSB-first; sampled only when a load is accepted.
REQ-007 The block SHALL have port en, input, 1 bit: shift enable; when 0, the current bit is held.
REQ-008 The block SHALL have port q, output, 1 bit: serial data bit.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a word is being shifted out.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit is consumed.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE, load=1 at a clock edge SHALL be accepted: din and dir are captured, the bit counter is cleared, and the state becomes SHIFT.
REQ-013 In IDLE, load=0 SHALL leave the state at IDLE.
REQ-014 In SHIFT, q SHALL present the current bit combinationally from the holding register: din[cnt] when dir=0, din[WIDTH-1-cnt] when dir=1.
REQ-015 The first bit SHALL appear on q in the first cycle after load acceptance (latency 1 cycle).
REQ-016 In SHIFT, en=1 at a clock edge SHALL consume the current bit: the counter increments when cnt < WIDTH-1; when cnt = WIDTH-1, the state becomes DONE.
REQ-017 In SHIFT, en=0 SHALL hold cnt, q, and the state unchanged for any number of cycles.
REQ-018 busy SHALL be 1 exactly when the state is SHIFT.
REQ-019 done SHALL be 1 exactly when the state is DONE, which lasts exactly one cycle.
REQ-020 q SHALL be 0 in IDLE and DONE.
REQ-021 load asserted while in SHIFT SHALL be ignored: no recapture, counter unchanged.
REQ-022 In DONE, load=1 SHALL be accepted exactly as in IDLE and move to SHIFT (back-to-back words, one gap cycle); otherwise the state SHALL become IDLE.
REQ-023 dir or din changes after acceptance SHALL NOT affect the word in flight.
REQ-024 The counter width SHALL be ceil(log2(WIDTH)) bits and SHALL never exceed WIDTH-1.
REQ-025 A word with en held at 1 throughout SHALL complete in WIDTH cycles of busy=1 followed by one cycle of done=1.

Reset
REQ-026 rst=1 at a clock edge SHALL force: state IDLE, counter 0, holding register 0, q=0, busy=0, done=0.
REQ-027 Reset SHALL take priority over load and en in the same cycle.
REQ-028 Reset asserted during SHIFT or DONE SHALL abort the word with no done pulse.
REQ-029 The block SHALL accept a load on the first edge after rst deasserts.

Verification
REQ-030 Scenario (WIDTH=4): rst 2 cycles, then load=1, din=4'b1011, dir=0, en=1 -> q sequence 1,1,0,1 over 4 busy cycles, then done=1 for 1 cycle, then IDLE.
REQ-031 Scenario: same word with dir=1 -> q sequence 1,0,1,1, done pulse after the 4th bit.
REQ-032 Scenario: load 4'b0110, dir=0; en=0 for 3 cycles after the 2nd bit -> q held at 1 for those cycles, busy stays 1, total busy cycles 7, sequence 0,1,1,0.
REQ-033 Scenario: load 4'b1111, then load=1 with din=4'b0000 during SHIFT -> output remains 1,1,1,1; the second load is ignored.
REQ-034 Scenario: load 4'b1001 held high through the DONE cycle with din=4'b0101 -> second word 1,0,1,0 starts in the cycle after done; busy is low only in the done cycle.
REQ-035 Scenario: rst=1 asserted after the 2nd bit of 4'b1010 -> next cycle q=0, busy=0, done=0 and no done pulse follows; a new load is accepted afterward.
